// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an ALU operation and holds it in a 1- or 2-entry skid buffer.
// Optional macro ALU_NOR_EN adds R-type funct 100111 (nor) to the decode table.
module alu_issue_stage #(
    parameter int DEPTH_TWO = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  aluop,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    input  logic        alusrc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  ALUctl,
    output logic        illegal
);

    localparam int DATA_W = 32;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
`ifdef ALU_NOR_EN
    localparam logic [3:0] CTL_NOR = 4'b1100;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
        logic [3:0]               ctl;
        logic                     ill;
    } entry_t;

    // Returns {illegal, ALUctl}; unknown R-type functs fall back to add and flag illegal.
    function automatic logic [4:0] decode_op(input logic [1:0] op, input logic [5:0] fn);
        logic [4:0] r;
        r = {1'b0, CTL_ADD};
        case (op)
            2'b00: r = {1'b0, CTL_ADD};
            2'b01: r = {1'b0, CTL_SUB};
            2'b11: r = {1'b0, CTL_OR};
            default: begin
                case (fn)
                    6'b100000: r = {1'b0, CTL_ADD};
                    6'b100010: r = {1'b0, CTL_SUB};
                    6'b100100: r = {1'b0, CTL_AND};
                    6'b100101: r = {1'b0, CTL_OR};
                    6'b101010: r = {1'b0, CTL_SLT};
`ifdef ALU_NOR_EN
                    6'b100111: r = {1'b0, CTL_NOR};
`endif
                    default:   r = {1'b1, CTL_ADD};
                endcase
            end
        endcase
        return r;
    endfunction

    // Logical immediates (ori) are zero-extended, arithmetic ones sign-extended.
    function automatic logic signed [DATA_W-1:0] ext_imm(input logic [15:0] im, input logic zext);
        logic signed [15:0]       s;
        logic signed [DATA_W-1:0] r;
        s = $signed(im);
        if (zext)
            r = {{(DATA_W-16){1'b0}}, im};
        else
            r = s;
        return r;
    endfunction

    occ_t   state, state_nxt;
    logic   in_ready_nxt;
    logic   acc, ret;
    logic   ld_head_new, ld_head_tail, ld_tail;
    entry_t new_ent;
    entry_t head_p0;
    entry_t tail_p1;

    assign acc = in_valid & in_ready;
    assign ret = out_valid & out_ready;

    always_comb begin
        logic [4:0] dec;
        dec         = decode_op(aluop, funct);
        new_ent.a   = $signed(rs_val);
        new_ent.b   = alusrc ? ext_imm(imm, aluop == 2'b11) : $signed(rt_val);
        new_ent.ctl = dec[3:0];
        new_ent.ill = dec[4];
    end

    // State register; in_ready is registered alongside the occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= in_ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (acc) state_nxt = ONE;
            ONE: begin
                if (acc && !ret)
                    state_nxt = (DEPTH_TWO != 0) ? TWO : ONE;
                else if (!acc && ret)
                    state_nxt = EMPTY;
            end
            TWO: if (ret) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid    = (state != EMPTY);
        ld_head_new  = acc && ((state == EMPTY) || ((state == ONE) && ret));
        ld_tail      = acc && (state == ONE) && !ret;
        ld_head_tail = ret && (state == TWO);
        if (DEPTH_TWO != 0)
            in_ready_nxt = (state_nxt != TWO);
        else
            in_ready_nxt = (state_nxt == EMPTY);
    end

    // Stage p0: head entry, drives the ALU outputs directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            head_p0 <= '0;
        else if (ld_head_new)
            head_p0 <= new_ent;
        else if (ld_head_tail)
            head_p0 <= tail_p1;
    end

    // Stage p1: skid entry, only ever occupied when DEPTH_TWO is set
    always_ff @(posedge clk) begin
        if (ld_tail)
            tail_p1 <= new_ent;
    end

    assign a       = head_p0.a;
    assign b       = head_p0.b;
    assign ALUctl  = head_p0.ctl;
    assign illegal = head_p0.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage (DEPTH_TWO=1): directed scenarios plus randomized traffic.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  aluop = '0;
    logic [5:0]  funct = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [15:0] imm = '0;
    logic        alusrc = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ALUctl;
    logic        illegal;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t q[$];
    int   ret_cyc[$];

    logic p_vld = 1'b0;
    logic p_rdy = 1'b0;
    exp_t p_data = '0;

    alu_issue_stage #(.DEPTH_TWO(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
        .imm(imm), .alusrc(alusrc), .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .ALUctl(ALUctl), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                                   input logic [31:0] rt, input logic [15:0] im, input logic src);
        exp_t e;
        e.a   = rs;
        e.ill = 1'b0;
        if (!src)
            e.b = rt;
        else if (op == 2'd3)
            e.b = 32'(im);
        else
            e.b = 32'(im) - (im[15] ? 32'h0001_0000 : 32'h0);
        case (op)
            2'd0: e.ctl = 4'd2;
            2'd1: e.ctl = 4'd6;
            2'd3: e.ctl = 4'd1;
            default: begin
                if (fn == 6'h20) e.ctl = 4'd2;
                else if (fn == 6'h22) e.ctl = 4'd6;
                else if (fn == 6'h24) e.ctl = 4'd0;
                else if (fn == 6'h25) e.ctl = 4'd1;
                else if (fn == 6'h2A) e.ctl = 4'd7;
`ifdef ALU_NOR_EN
                else if (fn == 6'h27) e.ctl = 4'd12;
`endif
                else begin
                    e.ctl = 4'd2;
                    e.ill = 1'b1;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: retire compare, hold/stall stability, then record accepts.
    always @(negedge clk) begin
        exp_t got, e;
        cyc++;
        got = '{a, b, ALUctl, illegal};
        if (rst_n) begin
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL orphan_output: out_valid=1 with a=%h b=%h ctl=%b, required no entry", a, b, ALUctl);
                end else if (out_ready) begin
                    e = q.pop_front();
                    ret_cyc.push_back(cyc);
                    if (got !== e) begin
                        errors++;
                        $display("FAIL retire: got a=%h b=%h ctl=%b ill=%b, want a=%h b=%h ctl=%b ill=%b",
                                 a, b, ALUctl, illegal, e.a, e.b, e.ctl, e.ill);
                    end
                end
            end
            if (p_vld && !p_rdy) begin
                checks++;
                if (!out_valid || got !== p_data) begin
                    errors++;
                    $display("FAIL stall_hold: got vld=%b data=%h, want vld=1 data=%h", out_valid, got, p_data);
                end
            end else if (!p_vld && !out_valid) begin
                checks++;
                if (got !== p_data) begin
                    errors++;
                    $display("FAIL idle_hold: got data=%h, want %h", got, p_data);
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(aluop, funct, rs_val, rt_val, imm, alusrc));
        end
        p_vld  = out_valid;
        p_rdy  = out_ready;
        p_data = got;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic check_head(input string nm, input logic [31:0] ea, input logic [31:0] eb,
                              input logic [3:0] ec, input logic ei);
        checks++;
        if (out_valid !== 1'b1 || a !== ea || b !== eb || ALUctl !== ec || illegal !== ei) begin
            errors++;
            $display("FAIL %s: got vld=%b a=%h b=%h ctl=%b ill=%b, want vld=1 a=%h b=%h ctl=%b ill=%b",
                     nm, out_valid, a, b, ALUctl, illegal, ea, eb, ec, ei);
        end
    endtask

    task automatic set_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [15:0] im, input logic src);
        aluop = op; funct = fn; rs_val = rs; rt_val = rt; imm = im; alusrc = src;
    endtask

    task automatic rand_op();
        logic [5:0] tbl [7];
        tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h3F};
        aluop  = 2'($urandom_range(0, 3));
        funct  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : tbl[$urandom_range(0, 6)];
        rs_val = $urandom;
        rt_val = $urandom;
        imm    = 16'($urandom);
        alusrc = 1'($urandom);
    endtask

    // Offer the current op and hold it until accepted (bounded).
    task automatic send();
        logic got;
        int   n;
        in_valid = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want accept", n);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_async();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_data", {a[15:0], b[15:0]} | 32'(|a) | 32'(|b), 32'd0);
        check("rst_ctl_ill", {27'd0, ALUctl, illegal}, 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] tmp;
        // Initial reset, then the basic subtract scenario.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("init_ready_high", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        set_op(2'b10, 6'b100010, 32'd7, 32'd3, 16'd0, 1'b0);
        send();
        in_valid = 1'b0;
        @(negedge clk);
        check_head("sub_latency", 32'd7, 32'd3, 4'b0110, 1'b0);
        idle(2);

        set_op(2'b00, 6'd0, 32'd5, 32'd9, 16'hFFFC, 1'b1);
        send();
        in_valid = 1'b0;
        @(negedge clk);
        check_head("add_sext", 32'd5, 32'hFFFF_FFFC, 4'b0010, 1'b0);
        set_op(2'b11, 6'd0, 32'd6, 32'd9, 16'hFFFC, 1'b1);
        send();
        in_valid = 1'b0;
        @(negedge clk);
        check_head("ori_zext", 32'd6, 32'h0000_FFFC, 4'b0001, 1'b0);

        set_op(2'b10, 6'b111111, 32'd1, 32'd2, 16'd0, 1'b0);
        send();
        in_valid = 1'b0;
        @(negedge clk);
        check_head("illegal_funct", 32'd1, 32'd2, 4'b0010, 1'b1);
        set_op(2'b10, 6'b100111, 32'd3, 32'd4, 16'd0, 1'b0);
        send();
        in_valid = 1'b0;
        @(negedge clk);
`ifdef ALU_NOR_EN
        check_head("nor_funct", 32'd3, 32'd4, 4'b1100, 1'b0);
`else
        check_head("nor_funct", 32'd3, 32'd4, 4'b0010, 1'b1);
`endif
        idle(3);

        // Skid fill with downstream stalled, then release.
        out_ready = 1'b0;
        set_op(2'b00, 6'd0, 32'd1, 32'd2, 16'd0, 1'b0);
        send();
        set_op(2'b01, 6'd0, 32'd10, 32'd20, 16'd0, 1'b0);
        send();
        set_op(2'b10, 6'b101010, 32'd30, 32'd40, 16'd0, 1'b0);
        fork
            send();
            begin
                @(negedge clk);
                check("full_ready_low", 32'(in_ready), 32'd0);
                check_head("stalled_head", 32'd1, 32'd2, 4'b0010, 1'b0);
                repeat (2) @(negedge clk);
                check("full_ready_held", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        idle(5);

        // Sustained throughput: ten back-to-back ops, no bubbles.
        ret_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            rand_op();
            send();
        end
        in_valid = 1'b0;
        idle(4);
        check("stream_count", 32'(ret_cyc.size()), 32'd10);
        if (ret_cyc.size() == 10) begin
            tmp = 32'(ret_cyc[9] - ret_cyc[0]);
            check("stream_no_bubble", tmp, 32'd9);
        end

        // Asynchronous reset with two entries buffered.
        out_ready = 1'b0;
        rand_op();
        send();
        rand_op();
        send();
        in_valid = 1'b0;
        reset_async();
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_stale_entry", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 1500; i++) begin
            logic acc;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    rand_op();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
